rca_serial_adder: RTL

- Multi-cycle ripple-carry adder for the tiny-gpu custom ALU path; the addition counterpart to the combinational 8-bit ripple-carry subtractor.
- Adds two unsigned WIDTH-bit operands CHUNK bits per clock, rippling the carry through a registered carry flop between cycles.
- Valid/ready handshake on both sides so the ALU scheduler can issue and drain results without fixed timing assumptions.
- Output is WIDTH+1 bits: bit WIDTH is the true carry-out, not the inverted carry used for borrow in the subtractor.

---
 rtl/rca_serial_adder_pkg.sv | 18 +
 rtl/rca_serial_adder_if.sv | 27 ++
 rtl/rca_chunk.sv | 25 ++
 rtl/rca_serial_adder.sv | 119 +++++++++++
 4 files changed

// File: rtl/rca_serial_adder_pkg.sv
// Shared definitions for the multi-cycle ALU units: FSM state type, default operand width
// and a counter-width helper.
package rca_serial_adder_pkg;

  localparam int unsigned AluWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } alu_state_e;

  // Width of a counter that must index n steps; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_serial_adder_if.sv
// Operand/result handshake bundle between the ALU scheduler (master) and an adder (slave).
interface rca_serial_adder_if
  import rca_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, busy
  );

endinterface

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry slice built from discrete full-adder stages.
module rca_chunk #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign s[i]     = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & p);
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/rca_serial_adder.sv
// Multi-cycle ripple-carry adder: adds two WIDTH-bit operands CHUNK bits per clock,
// carrying between cycles through a flop, with valid/ready on both sides.
module rca_serial_adder
  import rca_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth,
  parameter int unsigned CHUNK = 2
) (
  input logic              clk,
  input logic              reset,
  rca_serial_adder_if.slave bus
);

  localparam int unsigned NumChunks = WIDTH / CHUNK;
  localparam int unsigned CntW      = cnt_width(NumChunks);
  localparam logic [CntW-1:0]  LastChunk = CntW'(NumChunks - 1);
  localparam logic [WIDTH-1:0] SliceMask = WIDTH'({CHUNK{1'b1}});

  alu_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             accept;
  logic             last;
  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] s_slice;
  logic             c_out;

  assign accept  = bus.in_valid && (state_q == StIdle);
  assign last    = (cnt_q == LastChunk);
  assign shamt   = 32'(cnt_q) * CHUNK;
  assign a_slice = CHUNK'(a_q >> shamt);
  assign b_slice = CHUNK'(b_q >> shamt);

  rca_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_q),
    .s    (s_slice),
    .cout (c_out)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid)  state_d = StBusy;
      StBusy:  if (last)          state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.busy      = (state_q != StIdle);
    bus.sum       = sum_q;
  end

  // Datapath next state: each BUSY cycle merges one chunk into the result word.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = 1'b0;
      cnt_d   = '0;
      sum_d   = '0;
    end else if (state_q == StBusy) begin
      sum_d[WIDTH-1:0] = (sum_q[WIDTH-1:0] & ~(SliceMask << shamt)) |
                         (WIDTH'(s_slice) << shamt);
      carry_d = c_out;
      cnt_d   = cnt_q + CntW'(1);
      if (last) begin
        sum_d[WIDTH] = c_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
